rr_bus_arbiter_n: RTL and testbench

//  N-way round-robin bus arbiter; parametrised successor of the 4-way arbiter.

---
 rtl/rr_bus_arbiter_n_pkg.sv | 44 ++++
 rtl/rr_bus_arbiter_n_if.sv | 32 +++
 rtl/rr_bus_arbiter_n_prio_select.sv | 44 ++++
 rtl/rr_bus_arbiter_n.sv | 145 ++++++++++++++
 tb/tb_rr_bus_arbiter_n.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/rr_bus_arbiter_n_pkg.sv
// Shared arbitration types and the round-robin pick helper.
// Exports:
//   arb_state_t  - arbiter FSM states (ARB_IDLE, ARB_BUSY)
//   rr_pick_t    - result of a round-robin scan (found flag + winner index)
//   rr_pick()    - scans requests starting just after 'last', wrapping around
// Kept generic so weighted/other arbiters can reuse the same pick.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    // Widest requester vector the helper can handle; callers zero-extend.
    localparam int ARB_MAX_REQ   = 32;
    localparam int ARB_MAX_IDX_W = 5;

    typedef struct packed {
        logic                     found;
        logic [ARB_MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request found scanning last+1, last+2, ... modulo num_req.
    // The requester at 'last' is visited last, giving it the lowest priority.
    function automatic rr_pick_t rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                         input int num_req,
                                         input int last);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int i = 1; i <= ARB_MAX_REQ; i++) begin
            cand = last + i;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            if ((i <= num_req) && !res.found && req[cand[ARB_MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[ARB_MAX_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_n_if.sv
// Bus-side signal bundle of the round-robin arbiter.
// Signals:
//   request[NUM_REQ]  per-master bus request
//   lock              holder may not be preempted while high
//   grant[NUM_REQ]    one-hot grant (zero when idle)
//   grant_idx         binary index of the granted master (0 when idle)
//   grant_valid       any grant active
//   preempt           one-cycle pulse when a grant was ended by hold expiry
// Modports: master (requester side), slave (arbiter side).
interface rr_bus_arbiter_n_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] request;
    logic               lock;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               preempt;

    modport master (
        output request, lock,
        input  grant, grant_idx, grant_valid, preempt
    );

    modport slave (
        input  request, lock,
        output grant, grant_idx, grant_valid, preempt
    );

endinterface

// File: rtl/rr_bus_arbiter_n_prio_select.sv
// Combinational round-robin priority selector.
// Ports:
//   req[NUM_REQ]     candidate requests
//   last[IDX_W]      index granted most recently (lowest priority now)
//   onehot[NUM_REQ]  one-hot winner, zero when nothing requested
//   idx[IDX_W]       binary winner index, zero when nothing requested
//   found            at least one candidate request was set
module rr_prio_select
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [ARB_MAX_REQ-1:0] req_ext;
    rr_pick_t               pick;
    logic                   unused_idx_bits;

    // Widen the request vector to the fixed width the shared helper scans.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
    end

    assign pick            = rr_pick(req_ext, NUM_REQ, int'(last));
    assign found           = pick.found;
    assign idx             = pick.idx[IDX_W-1:0];
    assign unused_idx_bits = ^pick.idx;

    // Decode the binary winner back to one-hot for the grant register.
    always_comb begin
        onehot = '0;
        if (pick.found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_bus_arbiter_n.sv
// N-way round-robin bus arbiter driving the shared memory bus mux select.
// Grants one master at a time, keeps the grant while its request stays high,
// and preempts the holder after MAX_HOLD cycles if others wait and lock is low.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    rr_bus_arbiter_n_if.slave (request, lock in; grant, grant_idx,
//          grant_valid, preempt out; all outputs registered)
module rr_bus_arbiter_n
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    rr_bus_arbiter_n_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // MAX_HOLD of 0 disables the limit; keep a 1-bit counter so widths stay legal.
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    arb_state_t         state, state_n;
    logic [NUM_REQ-1:0] grant_r, grant_n;
    logic [IDX_W-1:0]   idx_r, idx_n;
    logic [IDX_W-1:0]   last_r, last_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic               valid_r;
    logic               preempt_r, preempt_n;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               active;
    logic               others;
    logic               expire;

    // The holder is masked out of the candidates: when it has dropped its bit is
    // already low, and on expiry it must not win again.  When idle grant is zero,
    // so the same mask serves both states.
    assign cand   = bus.request & ~grant_r;
    assign active = |(bus.request & grant_r);
    assign others = |cand;
    assign expire = (MAX_HOLD != 0) && !bus.lock && active && others && (cnt_r == HOLD_LAST);

    rr_prio_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .req    (cand),
        .last   (last_r),
        .onehot (win_onehot),
        .idx    (win_idx),
        .found  (win_found)
    );

    // Next-state logic: decides the next grant, pointer, hold count and preempt pulse.
    always_comb begin
        state_n   = state;
        grant_n   = grant_r;
        idx_n     = idx_r;
        last_n    = last_r;
        cnt_n     = cnt_r;
        preempt_n = 1'b0;
        case (state)
            ARB_IDLE: begin
                cnt_n = '0;
                if (win_found) begin
                    state_n = ARB_BUSY;
                    grant_n = win_onehot;
                    idx_n   = win_idx;
                    last_n  = win_idx;
                end
            end
            ARB_BUSY: begin
                if (!active || expire) begin
                    cnt_n = '0;
                    if (win_found) begin
                        grant_n   = win_onehot;
                        idx_n     = win_idx;
                        last_n    = win_idx;
                        preempt_n = expire;
                    end else begin
                        state_n = ARB_IDLE;
                        grant_n = '0;
                        idx_n   = '0;
                    end
                end else if (!bus.lock) begin
                    // Count only while someone else waits; lock freezes the count.
                    if (others) begin
                        cnt_n = (cnt_r == HOLD_SAT) ? cnt_r : cnt_r + 1'b1;
                    end else begin
                        cnt_n = '0;
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // State and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            grant_r   <= '0;
            idx_r     <= '0;
            valid_r   <= 1'b0;
            preempt_r <= 1'b0;
        end else begin
            state     <= state_n;
            grant_r   <= grant_n;
            idx_r     <= idx_n;
            valid_r   <= |grant_n;
            preempt_r <= preempt_n;
        end
    end

    // Hold counter for the current grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_n;
        end
    end

    // Round-robin pointer; resets to the top index so master 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= IDX_W'(NUM_REQ - 1);
        end else begin
            last_r <= last_n;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_idx   = idx_r;
    assign bus.grant_valid = valid_r;
    assign bus.preempt     = preempt_r;

endmodule

// File: tb/tb_rr_bus_arbiter_n.sv
// Testbench for rr_bus_arbiter_n.
// Three instances: A (4 masters, MAX_HOLD=3), B (4 masters, no hold limit),
// C (5 masters, MAX_HOLD=8).  A vector table drives requests, the expected
// outputs are queued when each vector is driven and compared one edge later.
module tb_rr_bus_arbiter_n;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    rr_bus_arbiter_n_if #(.NUM_REQ(4)) if_a ();
    rr_bus_arbiter_n_if #(.NUM_REQ(4)) if_b ();
    rr_bus_arbiter_n_if #(.NUM_REQ(5)) if_c ();

    rr_bus_arbiter_n #(.NUM_REQ(4), .MAX_HOLD(3)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    rr_bus_arbiter_n #(.NUM_REQ(4), .MAX_HOLD(0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    rr_bus_arbiter_n #(.NUM_REQ(5), .MAX_HOLD(8)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    always #5 clk = ~clk;

    // Grant is one-hot or zero, and only ever goes to a master that requested at the deciding edge.
    assert property (@(posedge clk) disable iff (reset) $onehot0(if_a.grant))
        else $error("[TB] FAIL onehot_a grant=%b", if_a.grant);
    assert property (@(posedge clk) disable iff (reset) $onehot0(if_b.grant))
        else $error("[TB] FAIL onehot_b grant=%b", if_b.grant);
    assert property (@(posedge clk) disable iff (reset) $onehot0(if_c.grant))
        else $error("[TB] FAIL onehot_c grant=%b", if_c.grant);
    assert property (@(posedge clk) disable iff (reset) ((if_a.grant & ~$past(if_a.request)) == '0))
        else $error("[TB] FAIL subset_a grant=%b", if_a.grant);
    assert property (@(posedge clk) disable iff (reset) ((if_b.grant & ~$past(if_b.request)) == '0))
        else $error("[TB] FAIL subset_b grant=%b", if_b.grant);
    assert property (@(posedge clk) disable iff (reset) ((if_c.grant & ~$past(if_c.request)) == '0))
        else $error("[TB] FAIL subset_c grant=%b", if_c.grant);

    typedef struct {
        int         dut;
        bit         rst;
        logic [4:0] req;
        logic       lock;
        logic [4:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       preempt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mkVec(int d, bit r, logic [4:0] rq, logic lk,
                                   logic [4:0] g, logic [2:0] ix, logic pe);
        vec_t v;
        v.dut     = d;
        v.rst     = r;
        v.req     = rq;
        v.lock    = lk;
        v.grant   = g;
        v.idx     = ix;
        v.valid   = |g;
        v.preempt = pe;
        return v;
    endfunction

    task automatic addVec(int d, bit r, logic [4:0] rq, logic lk,
                          logic [4:0] g, logic [2:0] ix, logic pe);
        tbl.push_back(mkVec(d, r, rq, lk, g, ix, pe));
    endtask

    // Packs {grant, idx, valid, preempt} of one instance into a common 10-bit word.
    function automatic logic [9:0] actualOf(int d);
        logic [9:0] a;
        a = '0;
        case (d)
            0:       a = {1'b0, if_a.grant, 1'b0, if_a.grant_idx, if_a.grant_valid, if_a.preempt};
            1:       a = {1'b0, if_b.grant, 1'b0, if_b.grant_idx, if_b.grant_valid, if_b.preempt};
            default: a = {if_c.grant, if_c.grant_idx, if_c.grant_valid, if_c.preempt};
        endcase
        return a;
    endfunction

    task automatic driveReq(int d, logic [4:0] r, logic l);
        case (d)
            0:       begin if_a.request = r[3:0]; if_a.lock = l; end
            1:       begin if_b.request = r[3:0]; if_b.lock = l; end
            default: begin if_c.request = r;      if_c.lock = l; end
        endcase
    endtask

    task automatic compare(input string name, input int n,
                           input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s #%0d: got {grant,idx,valid,preempt}=%b expected %b",
                     name, n, act, exp);
        end
    endtask

    // Holds every instance in reset with the vector's request applied, then checks all outputs are zero.
    task automatic resetDuts(input vec_t v);
        @(negedge clk);
        reset = 1'b1;
        for (int d = 0; d < 3; d++) driveReq(d, 5'b0, 1'b0);
        driveReq(v.dut, v.req, v.lock);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) compare("reset_out", d, actualOf(d), 10'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset = 1'b0;
        driveReq(v.dut, v.req, v.lock);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int n);
        vec_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s #%0d: scoreboard empty, got %b", name, n, actualOf(0));
        end else begin
            e = exp_q.pop_front();
            compare(name, n, actualOf(e.dut), {e.grant, e.idx, e.valid, e.preempt});
        end
    endtask

    initial begin
        vec_t v;
        for (int d = 0; d < 3; d++) driveReq(d, 5'b0, 1'b0);

        // Reset with all requesting, master 0 first, then MAX_HOLD=3 rotation 0->1->2.
        addVec(0, 1, 5'b01111, 0, 5'b00001, 3'd0, 0);
        addVec(0, 0, 5'b01111, 0, 5'b00001, 3'd0, 0);
        addVec(0, 0, 5'b01111, 0, 5'b00001, 3'd0, 0);
        addVec(0, 0, 5'b01111, 0, 5'b00010, 3'd1, 1);
        addVec(0, 0, 5'b01111, 0, 5'b00010, 3'd1, 0);
        addVec(0, 0, 5'b01111, 0, 5'b00010, 3'd1, 0);
        addVec(0, 0, 5'b01111, 0, 5'b00100, 3'd2, 1);
        // No hold limit: holders release in turn, no idle cycle, wrap back to 0.
        addVec(1, 1, 5'b01111, 0, 5'b00001, 3'd0, 0);
        for (int i = 0; i < 4; i++) addVec(1, 0, 5'b01111, 0, 5'b00001, 3'd0, 0);
        addVec(1, 0, 5'b01110, 0, 5'b00010, 3'd1, 0);
        addVec(1, 0, 5'b01111, 0, 5'b00010, 3'd1, 0);
        addVec(1, 0, 5'b01101, 0, 5'b00100, 3'd2, 0);
        addVec(1, 0, 5'b01111, 0, 5'b00100, 3'd2, 0);
        addVec(1, 0, 5'b01011, 0, 5'b01000, 3'd3, 0);
        addVec(1, 0, 5'b01111, 0, 5'b01000, 3'd3, 0);
        addVec(1, 0, 5'b00111, 0, 5'b00001, 3'd0, 0);
        addVec(1, 0, 5'b00000, 0, 5'b00000, 3'd0, 0);
        // Masters 0 and 2 constantly requesting: 3 cycles each with preempt pulses.
        addVec(0, 1, 5'b00101, 0, 5'b00001, 3'd0, 0);
        addVec(0, 0, 5'b00101, 0, 5'b00001, 3'd0, 0);
        addVec(0, 0, 5'b00101, 0, 5'b00001, 3'd0, 0);
        addVec(0, 0, 5'b00101, 0, 5'b00100, 3'd2, 1);
        addVec(0, 0, 5'b00101, 0, 5'b00100, 3'd2, 0);
        addVec(0, 0, 5'b00101, 0, 5'b00100, 3'd2, 0);
        addVec(0, 0, 5'b00101, 0, 5'b00001, 3'd0, 1);
        // Same with lock: no preemption; count was frozen so expiry comes 3 cycles after unlock.
        addVec(0, 1, 5'b00101, 1, 5'b00001, 3'd0, 0);
        for (int i = 0; i < 7; i++) addVec(0, 0, 5'b00101, 1, 5'b00001, 3'd0, 0);
        addVec(0, 0, 5'b00101, 0, 5'b00001, 3'd0, 0);
        addVec(0, 0, 5'b00101, 0, 5'b00001, 3'd0, 0);
        addVec(0, 0, 5'b00101, 0, 5'b00100, 3'd2, 1);
        // Lone requester is never preempted; a newcomer starts the hold count from zero.
        addVec(0, 1, 5'b00010, 0, 5'b00010, 3'd1, 0);
        for (int i = 0; i < 4; i++) addVec(0, 0, 5'b00010, 0, 5'b00010, 3'd1, 0);
        addVec(0, 0, 5'b00011, 0, 5'b00010, 3'd1, 0);
        addVec(0, 0, 5'b00011, 0, 5'b00010, 3'd1, 0);
        addVec(0, 0, 5'b00011, 0, 5'b00001, 3'd0, 1);
        addVec(0, 0, 5'b00000, 0, 5'b00000, 3'd0, 0);
        // Five masters: after master 4 held the bus, master 0 wins by wrap-around.
        addVec(2, 1, 5'b10000, 0, 5'b10000, 3'd4, 0);
        addVec(2, 0, 5'b00000, 0, 5'b00000, 3'd0, 0);
        addVec(2, 0, 5'b10001, 0, 5'b00001, 3'd0, 0);
        // Grant master 2 before the mid-grant reset below.
        addVec(0, 1, 5'b00100, 0, 5'b00100, 3'd2, 0);

        for (int n = 0; n < tbl.size(); n++) begin
            if (tbl[n].rst) resetDuts(tbl[n]);
            applyStimulus(tbl[n]);
            checkOutput("vec", n);
        end

        // Reset while master 2 holds the bus: outputs clear without waiting for a clock.
        @(negedge clk);
        reset = 1'b1;
        driveReq(0, 5'b00110, 1'b0);
        #1;
        compare("async_reset", 0, actualOf(0), 10'b0);
        // Pointer is back at the top index, so master 1 beats master 2.
        v = mkVec(0, 0, 5'b00110, 0, 5'b00010, 3'd1, 0);
        applyStimulus(v);
        checkOutput("after_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
